// File: rtl/s_axi_read_bank.sv
`default_nettype none
// ============================================================================
// Module   : s_axi_read_bank
// Purpose  : AXI4-Lite read responder for sequencer bank0/bank1 registers.
//            Define S_AXI_RD_SLVERR_EN to return SLVERR on unmapped reads.
// Revision : 1.0 - initial release
// ============================================================================
module s_axi_read_bank #(
  parameter int GLOB_ADDR_WIDTH      = 32,
  parameter int GLOB_DATA_WIDTH      = 32,
  parameter int BANK1_INDEX_WIDTH    = 2,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH,
  parameter int SLOTS                = 2**BANK1_INDEX_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [GLOB_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic                                  S_AXI_ARVALID,
  output logic                                  S_AXI_ARREADY,
  output logic [GLOB_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                            S_AXI_RRESP,
  output logic                                  S_AXI_RVALID,
  input  logic                                  S_AXI_RREADY,
  input  logic [BANK0_CONTROL_WIDTH-1:0]        bank0_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]         bank0_status,
  input  logic [BANK0_CNT_WIDTH-1:0]            bank0_cnt,
  input  logic [SLOTS*BANK1_SRC_ADDR_WIDTH-1:0] bank1_src_addr,
  input  logic [SLOTS*BANK1_SRC_SIZE_WIDTH-1:0] bank1_src_size,
  input  logic [SLOTS*BANK1_DST_ADDR_WIDTH-1:0] bank1_dst_addr,
  input  logic [SLOTS*BANK1_DST_SIZE_WIDTH-1:0] bank1_dst_size,
  input  logic [SLOTS*BANK1_STATUS_WIDTH-1:0]   bank1_status,
  input  logic [SLOTS*BANK1_PROFILE_WIDTH-1:0]  bank1_profile,
  output logic                                  rd_evt,
  output logic [GLOB_ADDR_WIDTH-1:0]            rd_evt_addr
);

  localparam int B = 5 + BANK1_INDEX_WIDTH;
  localparam int DW = GLOB_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef S_AXI_RD_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  if (BANK1_SRC_ADDR_WIDTH > DW || BANK1_SRC_SIZE_WIDTH > DW ||
      BANK1_DST_ADDR_WIDTH > DW || BANK1_DST_SIZE_WIDTH > DW ||
      BANK1_STATUS_WIDTH   > DW || BANK1_PROFILE_WIDTH  > DW ||
      BANK0_CONTROL_WIDTH  > DW || BANK0_STATUS_WIDTH   > DW ||
      BANK0_CNT_WIDTH      > DW) begin : g_width_check
    $error("s_axi_read_bank: a register field is wider than GLOB_DATA_WIDTH");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                         state_q;
  logic                           arready_q;
  logic                           rvalid_q;
  logic [DW-1:0]                  rdata_q;
  logic [1:0]                     rresp_q;
  logic                           rd_evt_q;
  logic [GLOB_ADDR_WIDTH-1:0]     rd_evt_addr_q;
  logic [DW-1:0]                  rdata_d;
  logic [1:0]                     rresp_d;
  logic [BANK1_INDEX_WIDTH-1:0]   slot;
  logic [2:0]                     field;
  logic [B-3:0]                   b0_word;
  logic                           unused_addr_lsbs;

  assign unused_addr_lsbs = ^S_AXI_ARADDR[1:0];
  assign slot    = S_AXI_ARADDR[B-1:5];
  assign field   = S_AXI_ARADDR[4:2];
  assign b0_word = S_AXI_ARADDR[B-1:2];

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    if (S_AXI_ARADDR[GLOB_ADDR_WIDTH-1:B+1] != '0) begin
      rresp_d = RESP_UNMAPPED;
    end else if (!S_AXI_ARADDR[B]) begin
      if (b0_word == (B-2)'(0))      rdata_d = DW'(bank0_control);
      else if (b0_word == (B-2)'(1)) rdata_d = DW'(bank0_status);
      else if (b0_word == (B-2)'(2)) rdata_d = DW'(bank0_cnt);
      else                           rresp_d = RESP_UNMAPPED;
    end else begin
      case (field)
        3'd0: rdata_d = DW'(bank1_src_addr[int'(slot)*BANK1_SRC_ADDR_WIDTH +: BANK1_SRC_ADDR_WIDTH]);
        3'd1: rdata_d = DW'(bank1_src_size[int'(slot)*BANK1_SRC_SIZE_WIDTH +: BANK1_SRC_SIZE_WIDTH]);
        3'd2: rdata_d = DW'(bank1_dst_addr[int'(slot)*BANK1_DST_ADDR_WIDTH +: BANK1_DST_ADDR_WIDTH]);
        3'd3: rdata_d = DW'(bank1_dst_size[int'(slot)*BANK1_DST_SIZE_WIDTH +: BANK1_DST_SIZE_WIDTH]);
        3'd4: rdata_d = DW'(bank1_status[int'(slot)*BANK1_STATUS_WIDTH +: BANK1_STATUS_WIDTH]);
        3'd5: rdata_d = DW'(bank1_profile[int'(slot)*BANK1_PROFILE_WIDTH +: BANK1_PROFILE_WIDTH]);
        default: rresp_d = RESP_UNMAPPED;
      endcase
    end
  end

  // Read data is snapshotted at the AR handshake and held until R completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
      rd_evt_q      <= 1'b0;
      rd_evt_addr_q <= '0;
    end else begin
      rd_evt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arready_q && S_AXI_ARVALID) begin
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            rvalid_q      <= 1'b1;
            arready_q     <= 1'b0;
            rd_evt_q      <= 1'b1;
            rd_evt_addr_q <= S_AXI_ARADDR;
            state_q       <= RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign rd_evt        = rd_evt_q;
  assign rd_evt_addr   = rd_evt_addr_q;

endmodule
`default_nettype wire
